// File: rtl/ifft_8_if.sv
// rtl/ifft_8_if.sv - bin-in / sample-out handshake bundle for the 8-point IFFT engine
interface ifft_8_if #(
  parameter int DATA_W = 12
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_img;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_img;
  logic                     out_last;
  logic                     busy;

  // Producer/consumer side driving bins in and draining samples out
  modport master (
    output in_valid, in_real, in_img, out_ready,
    input  in_ready, out_valid, out_real, out_img, out_last, busy
  );

  // Engine side
  modport slave (
    input  in_valid, in_real, in_img, out_ready,
    output in_ready, out_valid, out_real, out_img, out_last, busy
  );
endinterface

// File: rtl/ifft_8.sv
// rtl/ifft_8.sv - iterative 8-point radix-2 inverse FFT, one butterfly per clock, 1/2 scaling per stage
module ifft_8 #(
  parameter int DATA_W  = 12,
  parameter int TW_FRAC = 10
) (
  input logic     clk,
  input logic     rst_n,
  ifft_8_if.slave bus
);

  // Twiddles need two integer bits so that +1.0 and -0.707 are representable.
  localparam int TW_W   = TW_FRAC + 2;
  localparam int PROD_W = DATA_W + TW_W + 1;
  localparam int T_W    = DATA_W + 2;
  localparam int SUM_W  = DATA_W + 3;

  localparam int TW_C45_INT = int'(real'(2 ** TW_FRAC) * 0.7071067811865476);
  localparam logic signed [TW_W-1:0] TW_ONE  = TW_W'(2 ** TW_FRAC);
  localparam logic signed [TW_W-1:0] TW_C45  = TW_W'(TW_C45_INT);
  localparam logic signed [TW_W-1:0] TW_ZERO = '0;

  localparam logic signed [SUM_W-1:0] SAT_HI = {4'b0000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_LO = {4'b1111, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0] r_cnt;    // bin index in LOAD, sample index in UNLOAD
  logic [1:0] r_stage;
  logic [1:0] r_bfly;

  logic signed [DATA_W-1:0] r_re [8];
  logic signed [DATA_W-1:0] r_im [8];

  logic w_in_ready;
  logic w_out_valid;
  logic w_out_last;
  logic w_busy;
  logic w_load_fire;
  logic w_bfly_fire;
  logic w_out_fire;

  logic [2:0] w_top;
  logic [2:0] w_bot;
  logic [1:0] w_k;
  logic [2:0] w_load_addr;

  logic signed [TW_W-1:0]   w_tw_re;
  logic signed [TW_W-1:0]   w_tw_im;
  logic signed [DATA_W-1:0] w_top_re;
  logic signed [DATA_W-1:0] w_top_im;
  logic signed [DATA_W-1:0] w_bot_re;
  logic signed [DATA_W-1:0] w_bot_im;
  logic signed [PROD_W-1:0] w_prod_re;
  logic signed [PROD_W-1:0] w_prod_im;
  logic signed [T_W-1:0]    w_t_re;
  logic signed [T_W-1:0]    w_t_im;
  logic signed [SUM_W-1:0]  w_sum_re;
  logic signed [SUM_W-1:0]  w_sum_im;
  logic signed [SUM_W-1:0]  w_dif_re;
  logic signed [SUM_W-1:0]  w_dif_im;
  logic                     w_unused;

  // Halve (floor) and clamp to the output range instead of wrapping
  function automatic logic signed [DATA_W-1:0] sat_half(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] h;
    h = s >>> 1;
    if (h > SAT_HI) begin
      sat_half = SAT_HI[DATA_W-1:0];
    end else if (h < SAT_LO) begin
      sat_half = SAT_LO[DATA_W-1:0];
    end else begin
      sat_half = h[DATA_W-1:0];
    end
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    w_busy      = 1'b0;
    w_load_fire = 1'b0;
    w_bfly_fire = 1'b0;
    w_out_fire  = 1'b0;
    case (r_state)
      LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load_fire = 1'b1;
          if (r_cnt == 3'd7) w_state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        w_busy      = 1'b1;
        w_bfly_fire = 1'b1;
        if (r_stage == 2'd2 && r_bfly == 2'd3) w_state_nxt = UNLOAD;
      end
      UNLOAD: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        w_out_last  = (r_cnt == 3'd7);
        if (bus.out_ready) begin
          w_out_fire = 1'b1;
          if (r_cnt == 3'd7) w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // Butterfly addressing: top/bot differ only in bit 'stage'; k takes the low stage bits of j, scaled up
  always_comb begin
    w_top = 3'd0;
    w_bot = 3'd0;
    w_k   = 2'd0;
    case (r_stage)
      2'd0: begin
        w_top = {r_bfly, 1'b0};
        w_bot = {r_bfly, 1'b1};
        w_k   = 2'd0;
      end
      2'd1: begin
        w_top = {r_bfly[1], 1'b0, r_bfly[0]};
        w_bot = {r_bfly[1], 1'b1, r_bfly[0]};
        w_k   = {r_bfly[0], 1'b0};
      end
      default: begin
        w_top = {1'b0, r_bfly};
        w_bot = {1'b1, r_bfly};
        w_k   = r_bfly;
      end
    endcase
  end

  // Inverse twiddle ROM: W^-k = cos + j*sin of 2*pi*k/8
  always_comb begin
    w_tw_re = TW_ONE;
    w_tw_im = TW_ZERO;
    case (w_k)
      2'd0: begin w_tw_re = TW_ONE;   w_tw_im = TW_ZERO; end
      2'd1: begin w_tw_re = TW_C45;   w_tw_im = TW_C45;  end
      2'd2: begin w_tw_re = TW_ZERO;  w_tw_im = TW_ONE;  end
      default: begin w_tw_re = -TW_C45; w_tw_im = TW_C45; end
    endcase
  end

  assign w_load_addr = {r_cnt[0], r_cnt[1], r_cnt[2]};

  assign w_top_re = r_re[w_top];
  assign w_top_im = r_im[w_top];
  assign w_bot_re = r_re[w_bot];
  assign w_bot_im = r_im[w_bot];

  assign w_prod_re = PROD_W'(w_bot_re) * PROD_W'(w_tw_re) - PROD_W'(w_bot_im) * PROD_W'(w_tw_im);
  assign w_prod_im = PROD_W'(w_bot_re) * PROD_W'(w_tw_im) + PROD_W'(w_bot_im) * PROD_W'(w_tw_re);

  // Arithmetic shift by TW_FRAC; |t| <= 2^(DATA_W-1)*sqrt(2) so the dropped MSB is only sign
  assign w_t_re = w_prod_re[TW_FRAC +: T_W];
  assign w_t_im = w_prod_im[TW_FRAC +: T_W];

  assign w_sum_re = SUM_W'(w_top_re) + SUM_W'(w_t_re);
  assign w_sum_im = SUM_W'(w_top_im) + SUM_W'(w_t_im);
  assign w_dif_re = SUM_W'(w_top_re) - SUM_W'(w_t_re);
  assign w_dif_im = SUM_W'(w_top_im) - SUM_W'(w_t_im);

  assign w_unused = ^{w_prod_re[TW_FRAC-1:0], w_prod_re[PROD_W-1],
                      w_prod_im[TW_FRAC-1:0], w_prod_im[PROD_W-1]};

  // Register file, counters: bit-reversed load, in-place butterflies, sequential unload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 3'd0;
      r_stage <= 2'd0;
      r_bfly  <= 2'd0;
      for (int i = 0; i < 8; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else begin
      if (w_load_fire) begin
        r_re[w_load_addr] <= bus.in_real;
        r_im[w_load_addr] <= bus.in_img;
        r_cnt             <= r_cnt + 3'd1;
      end
      if (w_bfly_fire) begin
        r_re[w_top] <= sat_half(w_sum_re);
        r_im[w_top] <= sat_half(w_sum_im);
        r_re[w_bot] <= sat_half(w_dif_re);
        r_im[w_bot] <= sat_half(w_dif_im);
        r_bfly      <= r_bfly + 2'd1;
        if (r_bfly == 2'd3) begin
          r_stage <= (r_stage == 2'd2) ? 2'd0 : r_stage + 2'd1;
        end
      end
      if (w_out_fire) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.busy      = w_busy;
  assign bus.out_real  = w_out_valid ? r_re[r_cnt] : '0;
  assign bus.out_img   = w_out_valid ? r_im[r_cnt] : '0;

endmodule
